mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the pipeline's instruction-fetch (IF) port and data (MEM-stage) port.
- Grants one requester at a time and sequences the memory handshake.
- Returns read data with a one-cycle ready pulse; the pipeline uses the absence of ready as its stall condition.
- Includes a fetch-starvation guard and an unresponsive-memory timeout.

Parameters:
- AW, 32: address width.
- DW, 32: data width.
- MAX_D_STREAK, 4: number of consecutive data grants allowed while fetch is waiting; the next grant goes to fetch.
- TIMEOUT, 16: cycles in a BUSY state without mem_ack before the access is aborted. 0 disables the timeout.

Ports:
- clk in 1: clock.
- reset in 1: synchronous, active-high reset.
- if_req in 1: fetch request; held until if_ready.
- if_addr in AW: fetch address; stable while if_req is high.
- if_rdata out DW: fetched instruction; valid when if_ready=1.
- if_ready out 1: one-cycle completion pulse.
- d_req in 1: data request; held until d_ready.
- d_we in 1: 1 = write, 0 = read; stable with d_req.
- d_addr in AW: data address.
- d_wdata in DW: write data.
- d_rdata out DW: load data; valid when d_ready=1 and the access was a read.
- d_ready out 1: one-cycle completion pulse.
- mem_req out 1: memory request; held until mem_ack or abort.
- mem_we out 1: memory write enable.
- mem_addr out AW: memory address, registered at grant.
- mem_wdata out DW: memory write data, registered at grant.
- mem_rdata in DW: memory read data; sampled when mem_ack=1.
- mem_ack in 1: memory completion; may be high in the first mem_req cycle.
- bus_err out 1: one-cycle pulse, coincident with the ready pulse of a timed-out access.

Behaviour:
- Reset: synchronous. All outputs 0, state IDLE, counters 0.
- Reset mid-transaction: the access is abandoned; mem_req drops at the reset edge and no ready is issued.
- States: IDLE, BUSY_IF, BUSY_D, RESP_IF, RESP_D.
- IDLE, grant rules (registered decision):
  - Only d_req: grant data.
  - Only if_req: grant fetch.
  - Both: grant data unless d_streak==MAX_D_STREAK, in which case grant fetch.
  - Neither: stay IDLE.
- On grant: latch addr, we and wdata into the mem_* registers. mem_we=d_we for data and 0 for fetch. mem_req=1 from the next cycle.
- BUSY_x, mem_ack=1: capture mem_rdata, set mem_req=0, go to RESP_x.
- BUSY_x, timeout: if TIMEOUT!=0 and the wait counter reaches TIMEOUT-1 with no ack, set mem_req=0, load rdata=0, go to RESP_x and pulse bus_err in RESP_x.
- RESP_x: x_ready=1 for exactly one cycle, then go to IDLE. No re-arbitration in RESP, so a requester that deasserts req the cycle after ready is never double-served.
- Latency:
  - Zero-wait memory: request seen in cycle 0, mem_req in cycle 1, ready in cycle 2.
  - With memory wait W: ready in cycle 2+W.
  - Back-to-back minimum throughput is one access per 3 cycles.
- d_streak:
  - Increments on a data grant made while if_req=1, saturating at MAX_D_STREAK.
  - Clears on any fetch grant.
  - Clears in any IDLE cycle with if_req=0.
- Wait counter: clears on entry to BUSY_x and increments each BUSY cycle without ack.
- Read data hold: if_rdata and d_rdata hold their last value until the next completion on the same port.
- Data writes: a write completion leaves d_rdata unchanged.
- Timed-out reads return 0.
- Requests are ignored while not in IDLE.
- A request dropped before its grant is never issued.
- Dropping req after the grant does not cancel the access; it still completes and pulses ready.

Decomposition:
- Package mips_mem_pkg holds:
  - the arb_state_t enum (5 states);
  - AW/DW defaults;
  - the GRANT_IF/GRANT_D encodings.
- One sub-module, mem_arb_timer: wait counter plus timeout compare, with inputs clr, en, ack and output expired. It is reusable for the later cache-refill controller.

Test Plan:
- Single fetch, zero-wait memory: if_req=1, if_addr=0x40, mem_ack in the first mem_req cycle, mem_rdata=0x8C220004 → mem_addr=0x40, mem_we=0, if_ready pulse in cycle 2, if_rdata=0x8C220004.
- Simultaneous requests, MAX_D_STREAK=4: d_req and if_req held high for 6 accesses with 2-cycle memory wait → grant order D,D,D,D,IF,D; each ready is a single pulse; no overlapping mem_req.
- Data write: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF → mem_we=1, mem_wdata=0xDEADBEEF, d_ready pulse; d_rdata unchanged from its prior value.
- Timeout, TIMEOUT=16: d read with mem_ack never asserted → mem_req high for exactly 16 cycles then low; d_ready and bus_err pulse together the next cycle; d_rdata=0; the next fetch is served normally.
- Reset mid-BUSY_D: reset asserted on the 3rd wait cycle → mem_req=0 after the reset edge, no d_ready, state IDLE; a fresh fetch then completes in 2 cycles.
- Request withdrawn before grant: if_req pulsed for one cycle while BUSY_D → no fetch issued after RESP_D; mem_req stays 0.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mips_mem_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    // Which requester an IDLE-state decision selected.
    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_D  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUSY_IF,
        ST_BUSY_D,
        ST_RESP_IF,
        ST_RESP_D
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory port around the arbiter.
// slave: the arbiter's view. master: the pipeline/memory environment's view.
interface mem_port_arbiter_if
    import mips_mem_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) ();

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    logic          bus_err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, d_rdata, d_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, d_rdata, d_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );

endinterface

// File: rtl/mem_arb_timer.sv
// Wait-cycle counter with a timeout compare. Cleared when an access is
// launched, counts busy cycles without an ack, and flags the last allowed
// cycle. TIMEOUT of 0 means the access may wait forever.
module mem_arb_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic ack,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count_reg;

    // Count waiting cycles; saturate so a disabled timeout never wraps.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count_reg <= '0;
        end else if (en && !ack && (count_reg != {CW{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign expired = 1'b0;
        end else begin : g_timeout
            assign expired = en && !ack && (count_reg == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported variable-latency memory between the fetch and
// data ports. One access at a time: IDLE -> BUSY_x -> RESP_x -> IDLE, with a
// data-streak limit so fetch cannot starve and a timeout for a dead memory.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW           = DEF_AW,
    parameter int DW           = DEF_DW,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    localparam int SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;

    arb_state_t    state_reg, state_next;
    logic [SW-1:0] d_streak_reg;
    logic [AW-1:0] mem_addr_reg;
    logic          mem_we_reg;
    logic [DW-1:0] mem_wdata_reg;
    logic [DW-1:0] if_rdata_reg;
    logic [DW-1:0] d_rdata_reg;
    logic          err_reg;

    logic grant;
    logic grant_valid;
    logic busy;
    logic done;
    logic expired;
    logic streak_full;

    assign busy        = (state_reg == ST_BUSY_IF) || (state_reg == ST_BUSY_D);
    assign done        = busy && (bus.mem_ack || expired);
    assign streak_full = (d_streak_reg == SW'(MAX_D_STREAK));

    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (grant_valid),
        .en      (busy),
        .ack     (bus.mem_ack),
        .expired (expired)
    );

    // Next-state and grant decision; arbitration happens only in IDLE.
    always_comb begin
        state_next  = state_reg;
        grant       = GRANT_D;
        grant_valid = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (bus.d_req || bus.if_req) begin
                    grant_valid = 1'b1;
                    if (bus.d_req && !(bus.if_req && streak_full)) begin
                        grant = GRANT_D;
                    end else begin
                        grant = GRANT_IF;
                    end
                    state_next = (grant == GRANT_D) ? ST_BUSY_D : ST_BUSY_IF;
                end
            end
            ST_BUSY_IF: if (done) state_next = ST_RESP_IF;
            ST_BUSY_D:  if (done) state_next = ST_RESP_D;
            ST_RESP_IF: state_next = ST_IDLE;
            ST_RESP_D:  state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // Latch the granted request and capture (or zero) the returned data.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_reg  <= '0;
            mem_we_reg    <= 1'b0;
            mem_wdata_reg <= '0;
            if_rdata_reg  <= '0;
            d_rdata_reg   <= '0;
            err_reg       <= 1'b0;
        end else begin
            if (grant_valid) begin
                mem_addr_reg  <= (grant == GRANT_D) ? bus.d_addr : bus.if_addr;
                mem_we_reg    <= (grant == GRANT_D) && bus.d_we;
                mem_wdata_reg <= (grant == GRANT_D) ? bus.d_wdata : '0;
                err_reg       <= 1'b0;
            end
            if (done) begin
                // Ack wins over a coincident expiry, so err only on a real timeout.
                err_reg <= !bus.mem_ack;
                if (state_reg == ST_BUSY_IF) begin
                    if_rdata_reg <= bus.mem_ack ? bus.mem_rdata : '0;
                end else if (!mem_we_reg) begin
                    d_rdata_reg <= bus.mem_ack ? bus.mem_rdata : '0;
                end
            end
        end
    end

    // Data-streak counter: counts data grants that kept a waiting fetch out.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_streak_reg <= '0;
        end else if (state_reg == ST_IDLE) begin
            if (!bus.if_req || (grant_valid && grant == GRANT_IF)) begin
                d_streak_reg <= '0;
            end else if (grant_valid && !streak_full) begin
                d_streak_reg <= d_streak_reg + 1'b1;
            end
        end
    end

    assign bus.mem_req   = busy;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.if_rdata  = if_rdata_reg;
    assign bus.d_rdata   = d_rdata_reg;
    assign bus.if_ready  = (state_reg == ST_RESP_IF);
    assign bus.d_ready   = (state_reg == ST_RESP_D);
    assign bus.bus_err   = err_reg && ((state_reg == ST_RESP_IF) || (state_reg == ST_RESP_D));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural memory.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(
        .AW(32), .DW(32), .MAX_D_STREAK(4), .TIMEOUT(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    // Memory model controls.
    bit          mem_auto  = 1'b1;
    int          mem_wait  = 0;
    bit          mem_fixed = 1'b0;
    logic [31:0] mem_data  = 32'h0;
    int          wcnt      = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one clock, then let the memory model react to mem_req.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.mem_req) begin
            if (mem_auto && wcnt == mem_wait) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem_fixed ? mem_data : (bus.mem_addr ^ 32'h5A5A_0000);
            end else begin
                bus.mem_ack   = 1'b0;
            end
            wcnt++;
        end else begin
            bus.mem_ack = 1'b0;
            wcnt = 0;
        end
    endtask

    initial begin
        int  n_acc, g, run, dbl, both, n;
        bit  prev_req, prev_rdy, seen;
        logic [5:0] order;

        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0; bus.mem_ack = 0;

        // Reset state
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_mem_req",  bus.mem_req,  0);
        chk("rst_ready",    {bus.if_ready, bus.d_ready}, 0);
        chk("rst_bus_err",  bus.bus_err,  0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_rdata",    {bus.if_rdata, bus.d_rdata}, 0);

        // Single fetch, zero-wait memory
        mem_fixed = 1; mem_data = 32'h8C22_0004; mem_wait = 0;
        bus.if_req = 1; bus.if_addr = 32'h40;
        tick();
        chk("f1_mem_req",  bus.mem_req, 1);
        chk("f1_mem_addr", bus.mem_addr, 32'h40);
        chk("f1_mem_we",   bus.mem_we, 0);
        chk("f1_ready_c1", bus.if_ready, 0);
        tick();
        chk("f1_ready_c2", bus.if_ready, 1);
        chk("f1_rdata",    bus.if_rdata, 32'h8C22_0004);
        chk("f1_mreq_off", bus.mem_req, 0);
        bus.if_req = 0;
        tick();
        chk("f1_ready_end", bus.if_ready, 0);
        mem_fixed = 0;

        // Simultaneous requests, 2-cycle memory wait: expect D,D,D,D,IF,D
        mem_wait = 2;
        bus.if_req = 1; bus.if_addr = 32'h80;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
        n_acc = 0; g = 0; run = 0; dbl = 0; both = 0; prev_req = 0; prev_rdy = 0;
        order = '0;
        for (int c = 0; c < 80 && n_acc < 6; c++) begin
            tick();
            if (bus.mem_req && !prev_req && g < 6) begin
                order[g] = (bus.mem_addr == 32'h200);
                g++;
            end
            if (bus.mem_req) run++;
            if (!bus.mem_req && prev_req) begin
                chk("streak_mreq_len", run, 3);
                run = 0;
            end
            if (bus.if_ready && bus.d_ready) both++;
            if ((bus.if_ready || bus.d_ready) && prev_rdy) dbl++;
            prev_rdy = bus.if_ready || bus.d_ready;
            prev_req = bus.mem_req;
            if (bus.if_ready || bus.d_ready) n_acc++;
            if (n_acc == 6) begin
                bus.if_req = 0; bus.d_req = 0;
            end
        end
        chk("streak_grants",  g, 6);
        chk("streak_done",    n_acc, 6);
        chk("streak_order",   order, 6'b101111);
        chk("streak_dbl_rdy", dbl, 0);
        chk("streak_both",    both, 0);
        chk("streak_d_rdata", bus.d_rdata, 32'h5A5A_0200);
        chk("streak_if_rdata", bus.if_rdata, 32'h5A5A_0080);
        tick();

        // Data write: d_rdata must keep its previous read value
        mem_wait = 0;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
        tick();
        chk("wr_mem_we",    bus.mem_we, 1);
        chk("wr_mem_addr",  bus.mem_addr, 32'h100);
        chk("wr_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        tick();
        chk("wr_d_ready",   bus.d_ready, 1);
        chk("wr_d_rdata",   bus.d_rdata, 32'h5A5A_0200);
        bus.d_req = 0; bus.d_we = 0;
        tick();
        chk("wr_ready_end", bus.d_ready, 0);

        // Timeout: no ack ever
        mem_auto = 0;
        bus.d_req = 1; bus.d_addr = 32'h300;
        tick();
        n = 0;
        while (bus.mem_req && n < 40) begin
            n++;
            tick();
        end
        chk("to_mreq_cycles", n, 16);
        chk("to_d_ready",     bus.d_ready, 1);
        chk("to_bus_err",     bus.bus_err, 1);
        chk("to_d_rdata",     bus.d_rdata, 0);
        bus.d_req = 0;
        tick();
        chk("to_err_end",     {bus.bus_err, bus.d_ready}, 0);
        mem_auto = 1;
        bus.if_req = 1; bus.if_addr = 32'h44;
        tick();
        tick();
        chk("to_fetch_ready", bus.if_ready, 1);
        chk("to_fetch_rdata", bus.if_rdata, 32'h5A5A_0044);
        chk("to_fetch_err",   bus.bus_err, 0);
        bus.if_req = 0;
        tick();

        // Reset during BUSY_D on the 3rd wait cycle
        mem_auto = 0;
        bus.d_req = 1; bus.d_addr = 32'h304;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        chk("rb_mem_req",  bus.mem_req, 0);
        chk("rb_d_ready",  bus.d_ready, 0);
        reset = 1'b0; bus.d_req = 0;
        tick();
        chk("rb_idle",     {bus.mem_req, bus.d_ready}, 0);
        mem_auto = 1;
        bus.if_req = 1; bus.if_addr = 32'h48;
        tick();
        chk("rb_f_addr",   bus.mem_addr, 32'h48);
        tick();
        chk("rb_f_ready",  bus.if_ready, 1);
        chk("rb_f_rdata",  bus.if_rdata, 32'h5A5A_0048);
        bus.if_req = 0;
        tick();

        // Fetch request withdrawn before it could be granted
        mem_wait = 2;
        bus.d_req = 1; bus.d_addr = 32'h308;
        tick();
        bus.if_req = 1;
        tick();
        bus.if_req = 0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (bus.d_ready) seen = 1;
        end
        chk("wd_d_ready", seen, 1);
        chk("wd_d_rdata", bus.d_rdata, 32'h5A5A_0308);
        bus.d_req = 0;
        n = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.mem_req || bus.if_ready) n++;
        end
        chk("wd_no_fetch", n, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
